// File: rtl/bs_pkg.sv
// Shared definitions for the registered 1:2 demux: slot states, default word width, counter width.
package bs_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W     = 8;
  localparam int NUM_CH    = 2;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_st_e;
endpackage

// File: rtl/bs_out_slot.sv
// One-entry output register with valid/ready handshake; optional transfer counter (BS_DEMUX_CNT_EN).
module bs_out_slot
  import bs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_can
`ifdef BS_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] o_cnt
`endif
);
  slot_st_e         r_st;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = (r_st == FULL) && i_ready;
  assign o_can   = (r_st == EMPTY) || i_ready;
  assign o_data  = r_data;
  assign o_valid = (r_st == FULL);

  // A load wins over a drain so the slot sustains one word per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= EMPTY;
      r_data <= '0;
    end else if (i_load) begin
      r_st   <= FULL;
      r_data <= i_data;
    end else if (w_drain) begin
      r_st   <= EMPTY;
    end
  end

`ifdef BS_DEMUX_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cnt <= '0;
    else if (w_drain) r_cnt <= r_cnt + 1'b1;
  end
  assign o_cnt = r_cnt;
`endif
endmodule

// File: rtl/bs_4_demux12_reg.sv
// Registered 1:2 demux with per-channel output slots; BS_DEMUX_CNT_EN adds per-channel transfer counters.
module bs_4_demux12_reg
  import bs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s,
  input  logic [WIDTH-1:0] data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_valid,
  output logic             b_valid,
  input  logic             a_ready,
  input  logic             b_ready
`ifdef BS_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
`endif
);
  logic [NUM_CH-1:0]            w_ready, w_load, w_can, w_valid;
  logic [NUM_CH-1:0][WIDTH-1:0] w_dout;
`ifdef BS_DEMUX_CNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] w_cnt;
`endif

  // Only the selected channel's capacity gates acceptance.
  assign in_ready = s ? w_can[1] : w_can[0];
  assign w_ready  = {b_ready, a_ready};
  assign w_load   = {in_valid && in_ready && s, in_valid && in_ready && !s};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    bs_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load[g]),
      .i_data (data),
      .i_ready(w_ready[g]),
      .o_data (w_dout[g]),
      .o_valid(w_valid[g]),
      .o_can  (w_can[g])
`ifdef BS_DEMUX_CNT_EN
      , .o_cnt(w_cnt[g])
`endif
    );
  end

  assign a       = w_dout[0];
  assign b       = w_dout[1];
  assign a_valid = w_valid[0];
  assign b_valid = w_valid[1];
`ifdef BS_DEMUX_CNT_EN
  assign a_cnt = w_cnt[0];
  assign b_cnt = w_cnt[1];
`endif
endmodule

// File: tb/tb_bs_4_demux12_reg.sv
// Random + directed bench for bs_4_demux12_reg against a per-channel occupancy model (counters under BS_DEMUX_CNT_EN).
module tb_bs_4_demux12_reg;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s = 1'b0;
  logic [W-1:0] data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         a_valid, b_valid;
  logic         a_ready = 1'b1;
  logic         b_ready = 1'b1;
`ifdef BS_DEMUX_CNT_EN
  logic [7:0]   a_cnt, b_cnt;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: each channel either holds one word or nothing.
  bit           m_full [2];
  logic [W-1:0] m_word [2];
  int           m_xfers[2];

  always #5 clk = ~clk;

  bs_4_demux12_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .data(data),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .a_valid(a_valid), .b_valid(b_valid),
    .a_ready(a_ready), .b_ready(b_ready)
`ifdef BS_DEMUX_CNT_EN
    , .a_cnt(a_cnt), .b_cnt(b_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_full[c] = 0; m_word[c] = '0; m_xfers[c] = 0;
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ":a_valid"}, a_valid, m_full[0]);
    chk({tag, ":b_valid"}, b_valid, m_full[1]);
    if (m_full[0]) chk({tag, ":a"}, a, m_word[0]);
    if (m_full[1]) chk({tag, ":b"}, b, m_word[1]);
`ifdef BS_DEMUX_CNT_EN
    chk({tag, ":a_cnt"}, a_cnt, m_xfers[0] % 256);
    chk({tag, ":b_cnt"}, b_cnt, m_xfers[1] % 256);
`endif
  endtask

  // Called at a negedge: drive, check in_ready, clock, update model, check outputs.
  task automatic cycle(input string tag, input bit sel, input logic [W-1:0] d,
                       input bit iv, input bit ar, input bit br);
    bit rdy[2];
    bit exp_rdy, acc;
    s = sel; data = d; in_valid = iv; a_ready = ar; b_ready = br;
    rdy[0] = ar; rdy[1] = br;
    #1;
    exp_rdy = !m_full[sel] || rdy[sel];
    chk({tag, ":in_ready"}, in_ready, exp_rdy);
    acc = iv && exp_rdy;
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      if (m_full[c] && rdy[c]) begin
        m_xfers[c]++;
        m_full[c] = 0;
      end
      if (acc && (int'(sel) == c)) begin
        m_full[c] = 1;
        m_word[c] = d;
      end
    end
    @(negedge clk);
    chk_outputs(tag);
  endtask

  initial begin
    int nvalid;
    model_reset();
    #1;
    chk("rst_async:a", a, 0);
    chk("rst_async:a_valid", a_valid, 0);
    chk("rst_async:b_valid", b_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst:in_ready", in_ready, 1);
    chk("rst:b", b, 0);
    @(negedge clk);

    // Routing
    cycle("route1", 0, 4'hA, 1, 1, 1);
    chk("route1:a_exp", a, 4'hA);
    cycle("route2", 1, 4'h5, 1, 1, 1);
    chk("route2:b_exp", b, 4'h5);
    cycle("route_idle", 0, 4'h0, 0, 1, 1);

    // Backpressure on a
    cycle("bp_load", 0, 4'h3, 1, 0, 1);
    cycle("bp_hold1", 0, 4'h7, 1, 0, 1);
    chk("bp_hold1:a_exp", a, 4'h3);
    cycle("bp_hold2", 0, 4'h7, 1, 0, 1);
    chk("bp_hold2:a_exp", a, 4'h3);
    // Independence: b accepts while a is stalled
    cycle("indep", 1, 4'hC, 1, 0, 1);
    chk("indep:b_exp", b, 4'hC);
    chk("indep:a_exp", a, 4'h3);
    cycle("bp_release", 0, 4'h7, 1, 1, 1);
    chk("bp_release:a_exp", a, 4'h7);
    cycle("drain_both", 0, 4'h0, 0, 1, 1);

    // Throughput: 16 back-to-back words on a
    nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      cycle("thru", 0, W'(i), 1, 1, 1);
      if (a_valid === 1'b1 && a === W'(i)) nvalid++;
    end
    chk("thru:count", nvalid, 16);
    cycle("thru_end", 0, 4'h0, 0, 1, 1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", 1'($urandom), W'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));

    // Reset while a word is held mid-transfer
    cycle("pre_rst", 0, 4'h9, 1, 0, 0);
    chk("pre_rst:a_valid_exp", a_valid, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst:a", a, 0);
    chk("mid_rst:a_valid", a_valid, 0);
    chk("mid_rst:b_valid", b_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    s = 1'b0; a_ready = 1'b0;
    #1;
    chk("post_rst:in_ready", in_ready, 1);
    @(negedge clk);

`ifdef BS_DEMUX_CNT_EN
    for (int i = 0; i < 257; i++) cycle("cnt", 1, W'(i), 1, 1, 1);
    cycle("cnt_drain", 1, 4'h0, 0, 1, 1);
    chk("cnt:b_cnt_exp", b_cnt, 1);
    chk("cnt:a_cnt_exp", a_cnt, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bs_4_demux12_reg.md
BS_4_DEMUX12_REG -- requirements
Module: bs_4_demux12_reg

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, data word width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: s  input  1  route select (0 -> channel a, 1 -> channel b), sampled with in_valid.
REQ-005 SHALL have port: data  input  WIDTH  input word.
REQ-006 SHALL have ports: in_valid input 1 (word offered); in_ready output 1 (word accepted this cycle).
REQ-007 SHALL have ports: a, b  output  WIDTH  registered channel words.
REQ-008 SHALL have ports: a_valid, b_valid  output  1  channel word present.
REQ-009 SHALL have ports: a_ready, b_ready  input  1  downstream consumer accepts.

Function
REQ-010 SHALL provide per-channel one-entry output register with states EMPTY (valid=0) and FULL (valid=1).
REQ-011 SHALL accept an input word when in_valid && in_ready; in_ready SHALL equal (s ? b_can : a_can), where x_can = !x_valid || x_ready.
REQ-012 SHALL present accepted word on selected channel output with x_valid=1 on the next cycle (latency 1); unselected channel SHALL be unaffected.
REQ-013 SHALL complete an output transfer when x_valid && x_ready; FULL -> EMPTY unless a new word loads into that channel in the same cycle.
REQ-014 SHALL, on simultaneous drain and load of the same channel, load the new word and keep x_valid=1 (full throughput, one word per cycle).
REQ-015 SHALL hold x and x_valid stable while x_valid && !x_ready.
REQ-016 SHALL hold x at its last value when EMPTY; x content is don't-care when x_valid=0 except after reset.
REQ-017 SHALL keep in_ready low whenever the selected channel is FULL and not draining; in_ready SHALL NOT depend on the unselected channel.
REQ-018 SHALL allow both channels to drain in the same cycle independently.

Reset
REQ-019 SHALL, on rst_n low at any time, immediately force a=0, b=0, a_valid=0, b_valid=0 and clear counters; words held mid-transfer are discarded.
REQ-020 SHALL drive in_ready per REQ-011 from reset state (both EMPTY -> in_ready=1) after rst_n deasserts.

Configuration
REQ-021 SHALL, with BS_DEMUX_CNT_EN defined, add outputs a_cnt, b_cnt (8 bits each) counting completed output transfers per channel, wrapping 255 -> 0, reset to 0.
REQ-022 SHALL, without BS_DEMUX_CNT_EN, omit a_cnt/b_cnt ports and logic; all other behaviour identical.

Structure
REQ-023 SHALL place channel-state enum (EMPTY/FULL), default WIDTH and counter width (8) in shared package bs_pkg.
REQ-024 SHALL instantiate one sub-module bs_out_slot (one-entry register with valid/ready) per channel; routing and in_ready logic SHALL live in the top module.

Verification
REQ-025 Reset: rst_n=0 mid-transfer with a_valid=1 -> a=0, a_valid=0, in_ready=1 after release.
REQ-026 Routing: s=0,data=4'hA then s=1,data=4'h5, both ready=1 -> a=4'hA,a_valid=1 in cycle 1; b=4'h5,b_valid=1 in cycle 2.
REQ-027 Backpressure: a_ready=0, a holds 4'h3, send s=0,data=4'h7 -> in_ready=0, a stays 4'h3 until a_ready=1, then 4'h7 next cycle.
REQ-028 Independence: a FULL with a_ready=0, send s=1,data=4'hC -> in_ready=1, b=4'hC next cycle, a unchanged.
REQ-029 Throughput: 16 back-to-back words s=0, a_ready=1 -> 16 consecutive a_valid cycles, no bubbles, data in order.
REQ-030 Counter (BS_DEMUX_CNT_EN): 257 transfers on channel b -> b_cnt=1, a_cnt=0.
